// File: rtl/nibble_serial_adder.sv
// Nibble-serial two-operand adder: one A/B nibble pair per beat, LSB nibble first.
// After NIBBLES beats the W-bit sum with carry-out and signed overflow is held until the consumer accepts it.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;

  logic            accept;
  logic [4:0]      nib_d;
  logic [3:0]      low3_d;

  assign in_ready  = (state_q != S_DONE) && !rst;
  // A beat that arrives together with clr belongs to the aborted operation.
  assign accept    = in_valid && in_ready && !clr;
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  // low3_d[3] is the carry into bit 3 of this nibble, needed for signed overflow.
  always_comb begin
    nib_d  = {1'b0, in_data[3:0]} + {1'b0, in_data[7:4]} + {4'b0000, carry_q};
    low3_d = {1'b0, in_data[2:0]} + {1'b0, in_data[6:4]} + {3'b000, carry_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            sum_q[{cnt_q, 2'b00} +: 4] <= nib_d[3:0];
            carry_q                    <= nib_d[4];
            if (cnt_q == LAST_CNT) begin
              state_q <= S_DONE;
              cout_q  <= nib_d[4];
              ovf_q   <= nib_d[4] ^ low3_d[3];
            end else begin
              state_q <= S_ACCUM;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          carry_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): directed vectors plus randomized
// operands, bubbles and back-pressure, checked against a whole-operand arithmetic model.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain W-bit addition of the whole operands; returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives beats first..last of operands a/b, with up to max_bubble idle cycles before each.
  task automatic send_beats(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int first, input int last, input int max_bubble);
    for (int k = first; k <= last; k++) begin
      int nb;
      int t;
      nb = $urandom_range(max_bubble, 0);
      for (int j = 0; j < nb; j++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        do_cycle();
      end
      in_valid = 1'b1;
      in_data  = {b[4*k +: 4], a[4*k +: 4]};
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
        do_cycle();
        t++;
      end
      if (in_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
      end
      do_cycle();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_data = 8'h1F; out_ready = 1'b0;
    do_cycle();
    do_cycle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if ({out_sum, out_cout, out_ovf} !== {{W{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b required 0/0/0", out_sum, out_cout, out_ovf);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, out_sum);
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
    logic [W-1:0] vb [3] = '{16'h4321, 16'h0001, 16'h0001};
    logic [W-1:0] vs [3] = '{16'h5555, 16'h0000, 16'h8000};
    logic         vc [3] = '{1'b0, 1'b1, 1'b0};
    logic         vo [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      send_beats(va[i], vb[i], 0, NIBBLES-2, 0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid: got %b required 0", i, out_valid); end
      send_beats(va[i], vb[i], NIBBLES-1, NIBBLES-1, 0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_latency: out_valid=%b required 1", i, out_valid); end
      checks++;
      if (out_sum !== vs[i] || out_cout !== vc[i] || out_ovf !== vo[i]) begin
        errors++;
        $display("FAIL vec%0d_result: sum=%h cout=%b ovf=%b required %h/%b/%b",
                 i, out_sum, out_cout, out_ovf, vs[i], vc[i], vo[i]);
      end
      $display("vector %0d: %h+%h -> sum=%h cout=%b ovf=%b", i, va[i], vb[i], out_sum, out_cout, out_ovf);
      out_ready = 1'b1;
      do_cycle();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_release: out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] a, b;
    logic [W+1:0] exp;
    a = W'($urandom); b = W'($urandom);
    exp = ref_add(a, b);
    out_ready = 1'b0;
    send_beats(a, b, 0, NIBBLES-1, 1);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = 8'($urandom);
      do_cycle();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_ovf, out_cout, out_sum} !== exp) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b ovf/cout/sum=%h required 1/0/%h",
                 c, out_valid, in_ready, {out_ovf, out_cout, out_sum}, exp);
      end
    end
    out_ready = 1'b1;
    do_cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    send_beats(16'h1234, 16'h4321, 0, NIBBLES-1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h5555 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL hold_followup: valid=%b sum=%h cout=%b required 1/5555/0", out_valid, out_sum, out_cout);
    end
    $display("hold: %h+%h held 5 cycles, followup sum=%h", a, b, out_sum);
    out_ready = 1'b1;
    do_cycle();
    out_ready = 1'b0;
  endtask

  // use_clr=0 aborts with rst, use_clr=1 aborts with clr while a carry-generating beat is offered.
  task automatic test_abort(input bit use_clr);
    out_ready = 1'b0;
    send_beats(16'hFFFF, 16'h0001, 0, 1, 0);
    in_valid = 1'b1;
    in_data  = 8'h1F;
    if (use_clr) clr = 1'b1;
    else         rst = 1'b1;
    do_cycle();
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort%0d_valid: got %b required 0", use_clr, out_valid); end
    send_beats(16'h1234, 16'h4321, 0, NIBBLES-1, 3);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h5555 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort%0d_result: valid=%b sum=%h cout=%b ovf=%b required 1/5555/0/0",
               use_clr, out_valid, out_sum, out_cout, out_ovf);
    end
    $display("abort via %s: sum=%h cout=%b", use_clr ? "clr" : "rst", out_sum, out_cout);
    out_ready = 1'b1;
    do_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] a, b;
      logic [W+1:0] exp;
      int dly;
      a = W'($urandom); b = W'($urandom);
      if (n % 5 == 0) b = ~a + W'($urandom_range(1, 0));
      exp = ref_add(a, b);
      out_ready = 1'b0;
      send_beats(a, b, 0, NIBBLES-1, 2);
      dly = $urandom_range(3, 0);
      for (int d = 0; d < dly; d++) do_cycle();
      checks++;
      if (out_valid !== 1'b1 || {out_ovf, out_cout, out_sum} !== exp) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h valid=%b ovf/cout/sum=%h required 1/%h",
                 n, a, b, out_valid, {out_ovf, out_cout, out_sum}, exp);
      end
      $display("random %0d: %h+%h -> sum=%h cout=%b ovf=%b", n, a, b, out_sum, out_cout, out_ovf);
      out_ready = 1'b1;
      do_cycle();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      logic [W-1:0] a, b;
      logic [W+1:0] exp;
      a = W'($urandom); b = W'($urandom);
      exp = ref_add(a, b);
      send_beats(a, b, 0, NIBBLES-1, 0);
      checks++;
      if (out_valid !== 1'b1 || {out_ovf, out_cout, out_sum} !== exp) begin
        errors++;
        $display("FAIL b2b%0d: valid=%b ovf/cout/sum=%h required 1/%h", n, out_valid, {out_ovf, out_cout, out_sum}, exp);
      end
      $display("back-to-back %0d: %h+%h -> sum=%h", n, a, b, out_sum);
      do_cycle();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d_release: out_valid=%b in_ready=%b required 0/1", n, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_hold();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
